// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: default widths, opcode map, FSM states.
package instr_encoder_pkg;

    localparam int unsigned DEF_B  = 16;
    localparam int unsigned DEF_W  = 5;
    localparam int unsigned DEF_AW = 11;

    // Opcode map, common with the instruction decoder
    localparam int unsigned OPC_W = 5;
    localparam logic [OPC_W-1:0] OP_HALT  = 5'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 5'd1;
    localparam logic [OPC_W-1:0] OP_LDV   = 5'd2;
    localparam logic [OPC_W-1:0] OP_LDI   = 5'd3;
    localparam logic [OPC_W-1:0] OP_ADDV  = 5'd4;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'd5;
    localparam logic [OPC_W-1:0] OP_SUBV  = 5'd6;
    localparam logic [OPC_W-1:0] OP_SUBI  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } state_e;

endpackage

// File: rtl/instr_encoder_opcode_check.sv
// Combinational legality test: only the opcodes OP_HALT..OP_SUBI are accepted.
module opcode_check
    import instr_encoder_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic [W-1:0] opcode,
    output logic         legal_c
);

    // Legal range is the contiguous block starting at zero
    always_comb begin
        legal_c = (32'(opcode) <= 32'(OP_SUBI));
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs streamed {opcode, operand} pairs into program-memory writes at sequential addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned B  = DEF_B,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned AW = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_opcode,
    input  logic [B-W-1:0]  in_operand,
    input  logic            in_last,
    output logic            prog_we,
    output logic [AW-1:0]   prog_addr,
    output logic [B-1:0]    prog_data,
    output logic            done,
    output logic            full,
    output logic            err_illegal,
    output logic [AW:0]     count
);

    localparam logic [AW-1:0] ADDR_MAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [B-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          legal_c;

    opcode_check #(.W(W)) u_opcode_check (
        .opcode  (in_opcode),
        .legal_c (legal_c)
    );

    // Next-state: start restarts from address 0 and discards a coincident transfer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;

        if (start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == ST_LOAD && in_valid) begin
            if (legal_c) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                data_d  = {in_opcode, in_operand};
                count_d = count_q + (AW+1)'(1);
                // Pointer saturates at the top address rather than wrapping
                ptr_d   = (ptr_q == ADDR_MAX) ? ptr_q : ptr_q + AW'(1);
                if (in_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (ptr_q == ADDR_MAX) begin
                    state_d = ST_FULL;
                    full_d  = 1'b1;
                end
            end else begin
                err_d = 1'b1;
                if (in_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end

        ready_d = (state_d == ST_LOAD);
    end

    // State and output registers; reset wins over start and any transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready    = ready_q;
    assign prog_we     = we_q;
    assign prog_addr   = addr_q;
    assign prog_data   = data_q;
    assign done        = done_q;
    assign full        = full_q;
    assign err_illegal = err_q;
    assign count       = count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter B, default 16: instruction word width in bits.
REQ-002 Parameter W, default 5: opcode field width in bits; operand field width is B-W.
REQ-003 Parameter AW, default 11: program-memory address width in bits.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a new load at address 0.
REQ-007 in_valid  input  1  the source presents an instruction.
REQ-008 in_ready  output  1  the block accepts an instruction this cycle.
REQ-009 in_opcode  input  W  opcode field.
REQ-010 in_operand  input  B-W  operand or immediate field.
REQ-011 in_last  input  1  marks the final instruction of a program.
REQ-012 prog_we  output  1  program-memory write strobe.
REQ-013 prog_addr  output  AW  program-memory write address.
REQ-014 prog_data  output  B  packed instruction word: {opcode, operand}.
REQ-015 done  output  1  load completed by in_last.
REQ-016 full  output  1  the last address was written without in_last.
REQ-017 err_illegal  output  1  sticky flag: an illegal opcode was received.
REQ-018 count  output  AW+1  number of words written since the last start.

Function
REQ-019 The FSM SHALL have four states: IDLE, LOAD, DONE, FULL.
REQ-020 in_ready SHALL be 1 only in LOAD.
REQ-021 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-022 Legal opcodes SHALL be 5'b00000 through 5'b00111: halt, store, load variable, load immediate, add variable, add immediate, subtract variable, subtract immediate.
REQ-023 A legal transfer at cycle t SHALL produce prog_we=1 for exactly cycle t+1, with prog_addr = write pointer and prog_data = {in_opcode, in_operand}.
REQ-024 After each write, the write pointer and count SHALL each increment by 1.
REQ-025 An illegal opcode (5'b01000 through 5'b11111) SHALL be consumed without a write, SHALL set err_illegal, and SHALL leave the pointer unchanged.
REQ-026 A transfer with in_last=1 SHALL move the FSM to DONE: in_ready=0 from cycle t+1, and done=1 from cycle t+1.
REQ-027 in_last on an illegal opcode SHALL still move the FSM to DONE, with no write.
REQ-028 A legal transfer to address 2^AW-1 without in_last SHALL move the FSM to FULL: full=1 and in_ready=0 from cycle t+1. The pointer SHALL NOT wrap.
REQ-029 A legal in_last transfer to address 2^AW-1 SHALL move the FSM to DONE; full SHALL stay 0.
REQ-030 A start pulse in IDLE, DONE or FULL SHALL, on the next edge: enter LOAD, clear the pointer, count, done, full and err_illegal.
REQ-031 A start pulse in LOAD SHALL restart the load at address 0. A transfer in the same cycle SHALL be discarded.
REQ-032 In DONE and FULL, done, full and count SHALL hold until start or reset.
REQ-033 prog_addr and prog_data SHALL be registered; their values are don't-care while prog_we=0.

Reset
REQ-034 When reset=1 on an edge, the block SHALL: set the FSM to IDLE; drive prog_we, in_ready, done, full and err_illegal to 0; set prog_addr, prog_data and count to 0.
REQ-035 reset SHALL take priority over start and over any transfer.
REQ-036 A reset mid-load SHALL cancel any write scheduled for the next cycle.

Structure
REQ-037 A shared package SHALL hold:
- the opcode constants OP_HALT through OP_SUBI (values 0 to 7), common with the instruction decoder;
- the FSM state encoding;
- the default B, W and AW.
REQ-038 One sub-module, opcode_check, SHALL implement the combinational legal-opcode test.

Verification
REQ-039 Reset, then start, then 3 legal words (0x0805, 0x1803, 0x3801, the last with in_last) -> writes at addresses 0, 1, 2 with that data; done=1; count=3.
REQ-040 With AW=3, start, then 8 legal words without in_last -> 8 writes at addresses 0 to 7; full=1; in_ready=0; no 9th write.
REQ-041 Opcode 5'b01010 between two legal words -> err_illegal=1; the legal words land at addresses 0 and 1.
REQ-042 Assert reset on the cycle after a transfer -> no prog_we; all outputs return to their REQ-034 values.
REQ-043 Start asserted in DONE -> count=0, done=0, err_illegal=0; the next word is written at address 0.
REQ-044 Hold in_valid=1 in IDLE for 5 cycles without start -> no transfer; no prog_we.
